sensor_alarm_array: RTL

Parametrised multi-channel sensor-to-buzzer alarm controller; successor to the fixed 8-sensor/8-buzzer state machine.
- Per channel: input synchroniser, debounce, alert/hold FSM, pulsed buzzer.
- Global escalation: when two or more channels are active, every active buzzer goes solid.
- Sits directly behind the top-level wrapper; sensor_in driven from ui_in, buzzer_out to uo_out.

---
 rtl/sensor_alarm_array.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sensor_alarm_array.sv
// Multi-channel sensor-to-buzzer alarm controller: sync, debounce, alert/hold FSM, pulsed buzzer.
// Optional macro STICKY_LATCH_EN: HOLD never times out, leaving only via ack, mask, ena=0 or re-assert.
module sensor_alarm_array #(
  parameter int NUM_CH          = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 50,
  parameter int BEEP_PERIOD     = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [NUM_CH-1:0]             sensor_in,
  input  logic [NUM_CH-1:0]             mask,
  input  logic                          ack,
  output logic [NUM_CH-1:0]             buzzer_out,
  output logic                          alarm_any,
  output logic                          combo_alarm,
  output logic [$clog2(NUM_CH+1)-1:0]   active_count
);

  localparam int CW      = $clog2(NUM_CH + 1);
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BEEP_W  = (BEEP_PERIOD > 1) ? $clog2(BEEP_PERIOD) : 1;

  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, ALERT, HOLD} state_t;

  logic [NUM_CH-1:0] s_meta, s_sync;
  state_t            state        [NUM_CH];
  state_t            state_nxt    [NUM_CH];
  logic [CNT_W-1:0]  cnt          [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt      [NUM_CH];
  logic [BEEP_W-1:0] beep_cnt     [NUM_CH];
  logic [BEEP_W-1:0] beep_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] beep_phase, beep_phase_nxt;
  logic [NUM_CH-1:0] active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta     <= '0;
      s_sync     <= '0;
      beep_phase <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]    <= IDLE;
        cnt[i]      <= '0;
        beep_cnt[i] <= '0;
      end
    end else begin
      s_meta     <= sensor_in;
      s_sync     <= s_meta;
      beep_phase <= beep_phase_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]    <= state_nxt[i];
        cnt[i]      <= cnt_nxt[i];
        beep_cnt[i] <= beep_cnt_nxt[i];
      end
    end
  end

  // The beep runs whenever a channel is active; entering IDLE or ALERT-from-DEBOUNCE overrides it below.
  always_comb begin
    beep_phase_nxt = beep_phase;
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt[i]    = state[i];
      cnt_nxt[i]      = cnt[i];
      beep_cnt_nxt[i] = beep_cnt[i];

      if (state[i] == ALERT || state[i] == HOLD) begin
        if (beep_cnt[i] == BEEP_LAST) begin
          beep_cnt_nxt[i]   = '0;
          beep_phase_nxt[i] = ~beep_phase[i];
        end else begin
          beep_cnt_nxt[i] = beep_cnt[i] + BEEP_W'(1);
        end
      end

      if (mask[i] || !ena) begin
        state_nxt[i]      = IDLE;
        cnt_nxt[i]        = '0;
        beep_cnt_nxt[i]   = '0;
        beep_phase_nxt[i] = 1'b0;
      end else begin
        case (state[i])
          IDLE: begin
            if (s_sync[i]) begin
              state_nxt[i] = DEBOUNCE;
              cnt_nxt[i]   = '0;
            end
          end
          DEBOUNCE: begin
            if (!s_sync[i]) begin
              state_nxt[i] = IDLE;
              cnt_nxt[i]   = '0;
            end else if (cnt[i] == DEB_LAST) begin
              state_nxt[i]      = ALERT;
              cnt_nxt[i]        = '0;
              beep_cnt_nxt[i]   = '0;
              beep_phase_nxt[i] = 1'b1;
            end else begin
              cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
          end
          ALERT: begin
            if (!s_sync[i]) begin
              state_nxt[i] = HOLD;
              cnt_nxt[i]   = '0;
            end
          end
          HOLD: begin
            if (s_sync[i]) begin
              state_nxt[i] = ALERT;
              cnt_nxt[i]   = '0;
            end else if (ack) begin
              state_nxt[i]      = IDLE;
              cnt_nxt[i]        = '0;
              beep_cnt_nxt[i]   = '0;
              beep_phase_nxt[i] = 1'b0;
            end
`ifdef STICKY_LATCH_EN
`else
            else if (cnt[i] == HOLD_LAST) begin
              state_nxt[i]      = IDLE;
              cnt_nxt[i]        = '0;
              beep_cnt_nxt[i]   = '0;
              beep_phase_nxt[i] = 1'b0;
            end else begin
              cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
`endif
          end
          default: state_nxt[i] = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      active[i]    = (state[i] == ALERT) || (state[i] == HOLD);
      active_count = active_count + CW'(active[i]);
    end
  end

  // Escalation: with two or more channels active every active buzzer is driven solid.
  assign alarm_any   = |active;
  assign combo_alarm = (32'(active_count) >= 32'd2);
  assign buzzer_out  = active & (beep_phase | {NUM_CH{combo_alarm}});

endmodule
